intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the CP0 register file.
- Captures 4 external interrupt sources and gates them with CP0 Status outputs (global enable, 4-bit mask).
- Picks the highest-priority pending source at a safe pipeline point and redirects fetch to that source's handler vector.
- Drives the CP0 EPC write port with the resume PC. Stays in service, single level with no nesting, until ERET.

Parameters:
- PC_W, `IM_ADDR_BIT, width of instruction-memory addresses (EPC, vectors).
- N_SRC, 4, number of interrupt sources. Fixed to match the 4-bit CP0 mask.
- VEC_BASE, 'h200 (word address), handler vector of source 0.
- VEC_STRIDE, 'h40 (words), vector spacing. vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to PC_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- intr_req  in  N_SRC  raw external requests. Asynchronous level; a rising edge is one request.
- intr_en  in  1  CP0 Status global interrupt enable
- intr_mask  in  N_SRC  CP0 Status mask; 1 = source enabled
- safe_pt  in  1  pipeline can be interrupted this cycle (valid instr, not a branch delay slot, no stall)
- resume_pc  in  PC_W  PC of the instruction to resume after the handler
- eret  in  1  ERET retiring this cycle (one-cycle pulse)
- epc_w_en  out  1  one-cycle write strobe to CP0 EPC
- epc_w_data  out  PC_W  value for EPC
- redirect  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  PC_W  handler vector
- in_service  out  N_SRC  one-hot id of the source being serviced; 0 when idle
- pending  out  N_SRC  latched pending requests (debug/display)

Behaviour:
- Reset (async, rst_n=0) values:
  - epc_w_en=0, redirect=0, epc_w_data=0, redirect_pc=0.
  - in_service=0, pending=0.
  - Synchronizer and edge flops cleared; state=IDLE.
- Input capture:
  - Each intr_req bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - Edge-to-pending latency is 3 cycles.
  - Pending is set on an edge whether or not the source is masked.
- Masked pending bits stay latched. They become eligible as soon as the mask bit goes to 1.
- eligible = pending & intr_mask & {N_SRC{intr_en}}.
- Priority: the lowest index wins (source 0 highest).
- State IDLE:
  - Condition: eligible!=0 and safe_pt=1, evaluated in the same cycle.
  - If it holds, then in that cycle:
    - Register epc_w_en=1 and epc_w_data=resume_pc.
    - Register redirect=1 and redirect_pc=vector(k), where k is the winning source.
    - Clear pending[k] and set in_service=onehot(k).
    - Next state is SERVICE.
  - The strobes are visible the following cycle, for exactly 1 cycle.
  - If eligible!=0 but safe_pt=0: hold, nothing taken, retry each cycle.
- State SERVICE:
  - No new interrupt is taken, regardless of eligible.
  - Pending bits keep accumulating.
  - eret=1 -> in_service=0, next state IDLE.
- ERET is honoured only in SERVICE; eret in IDLE is ignored.
- The earliest re-take after ERET is the cycle after the return to IDLE, with safe_pt required again.
- Simultaneous take of source k and a new edge on k in the same cycle: the set wins and pending[k] stays 1. Rationale: the new edge is a distinct request.
- Additional edges on a source that is already pending merge; a pending bit holds one request, with no counting.
- epc_w_en and redirect are always asserted together and never back-to-back.
- Only 2 states are required: IDLE and SERVICE. The encoding is local.
- Reset asserted mid-SERVICE drops the service immediately. All state and pending are cleared.

Decomposition:
- Shared package / Core.vh:
  - Interrupt source count.
  - VEC_BASE and VEC_STRIDE defaults.
  - CP0 Status bit positions: enable bit 0, mask bits 11:8.
- One sub-module: intr_sync_edge, a per-bit 2-flop synchronizer plus rising-edge pulse. It is instantiated N_SRC times; it is clocked and reset like the parent.
- The priority encoder and FSM stay in intr_ctrl.

Test Plan:
- Basic take:
  - Stimulus: intr_en=1, mask=4'b1111, safe_pt=1, resume_pc='h034; raise intr_req[2].
  - Response: pending[2]=1 at +3 cycles. epc_w_en=1 with epc_w_data='h034, and redirect=1 with redirect_pc='h280, both for one cycle. in_service=4'b0100.
- Priority:
  - Stimulus: raise intr_req[3] and intr_req[1] in the same cycle.
  - Response: source 1 is taken first (redirect_pc='h240) and pending=4'b1000. After eret, source 3 is taken (redirect_pc='h2C0).
- Gating:
  - Stimulus: mask=4'b1110, then raise intr_req[0].
  - Response: pending=4'b0001, with no epc_w_en or redirect. Set mask=4'b1111: take on the next safe_pt.
  - Stimulus: repeat with intr_en=0.
  - Response: no take.
- safe_pt hold:
  - Stimulus: source 0 is eligible while safe_pt=0 for 5 cycles, then 1.
  - Response: exactly one epc_w_en pulse, in the cycle after safe_pt rises.
- Service lockout:
  - Stimulus: while in_service=4'b0001, raise intr_req[0] again.
  - Response: no redirect and pending[0]=1. After eret, a second take of source 0 occurs.
- Reset mid-service:
  - Stimulus: assert rst_n=0 during SERVICE with pending=4'b0110.
  - Response: all outputs 0 immediately (asynchronous). After release, no take without new edges.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared constants and types for the interrupt controller.
//   - source count, default address width and handler vector layout
//   - CP0 Status bit positions feeding intr_en / intr_mask
//   - FSM state type used by intr_ctrl
package intr_ctrl_pkg;

  // Number of external interrupt sources; matches the 4-bit CP0 mask field.
  localparam int N_SRC_DEF      = 4;

  // Default instruction-memory word-address width (EPC and vectors).
  localparam int PC_W_DEF       = 12;

  // Handler vector of source i = VEC_BASE + i*VEC_STRIDE (word addresses).
  localparam int VEC_BASE_DEF   = 'h200;
  localparam int VEC_STRIDE_DEF = 'h40;

  // CP0 Status register layout that drives intr_en and intr_mask.
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_IM_MSB  = 11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

endpackage

// File: rtl/intr_ctrl_sync_edge.sv
// intr_sync_edge: one-bit 2-flop synchronizer followed by a rising-edge
// detector.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_async  in   raw asynchronous request level
//   edge_pulse out  one-cycle pulse on a synchronized rising edge
// The pulse is combinational from the flops, so the parent can latch it on
// the third clock edge after the input rises.
module intr_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic req_async,
  output logic edge_pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= req_async;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign edge_pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller feeding the CP0 register file.
// Latches edges from N_SRC external sources, gates them with CP0 Status
// (global enable + mask), and at a safe pipeline point takes the
// lowest-index eligible source: writes EPC, redirects fetch to the handler
// vector and stays in service (no nesting) until ERET.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   intr_req     in   raw asynchronous request levels
//   intr_en      in   CP0 Status global enable
//   intr_mask    in   CP0 Status mask (1 = enabled)
//   safe_pt      in   pipeline may be interrupted this cycle
//   resume_pc    in   PC to resume after the handler
//   eret         in   ERET retiring (pulse)
//   epc_w_en     out  EPC write strobe (1 cycle)
//   epc_w_data   out  EPC value
//   redirect     out  fetch redirect strobe (1 cycle)
//   redirect_pc  out  handler vector
//   in_service   out  one-hot source being serviced, 0 when idle
//   pending      out  latched pending requests
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int N_SRC      = N_SRC_DEF,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] intr_req,
  input  logic             intr_en,
  input  logic [N_SRC-1:0] intr_mask,
  input  logic             safe_pt,
  input  logic [PC_W-1:0]  resume_pc,
  input  logic             eret,
  output logic             epc_w_en,
  output logic [PC_W-1:0]  epc_w_data,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [N_SRC-1:0] in_service,
  output logic [N_SRC-1:0] pending
);

  state_e             state_reg, state_next;
  logic [N_SRC-1:0]   pending_reg, pending_next;
  logic [N_SRC-1:0]   in_service_reg, in_service_next;
  logic               epc_w_en_reg, epc_w_en_next;
  logic [PC_W-1:0]    epc_w_data_reg, epc_w_data_next;
  logic               redirect_reg, redirect_next;
  logic [PC_W-1:0]    redirect_pc_reg, redirect_pc_next;

  logic [N_SRC-1:0]   edge_pulse;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   win_onehot;
  logic [N_SRC:0]     higher_found;
  logic [PC_W-1:0]    vec_tab [N_SRC];
  logic [PC_W-1:0]    win_vec;
  logic               take;

  // Per-source capture path.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_sync
      intr_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_async  (intr_req[gi]),
        .edge_pulse (edge_pulse[gi])
      );
    end
  endgenerate

  assign eligible = pending_reg & intr_mask & {N_SRC{intr_en}};

  // Lowest index wins: a source is the winner only if no lower-index source
  // is eligible. higher_found[i] = some source below i is eligible.
  assign higher_found[0] = 1'b0;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_prio
      assign higher_found[gi+1] = higher_found[gi] | eligible[gi];
      assign win_onehot[gi]     = eligible[gi] & ~higher_found[gi];
      assign vec_tab[gi]        = PC_W'(VEC_BASE + gi * VEC_STRIDE);
    end
  endgenerate

  // win_onehot is one-hot (or zero), so OR-ing the selected entries is a mux.
  always_comb begin
    win_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_onehot[i]) begin
        win_vec = win_vec | vec_tab[i];
      end
    end
  end

  assign take = (state_reg == ST_IDLE) && (|eligible) && safe_pt;

  always_comb begin
    state_next       = state_reg;
    in_service_next  = in_service_reg;
    epc_w_en_next    = 1'b0;
    redirect_next    = 1'b0;
    epc_w_data_next  = epc_w_data_reg;
    redirect_pc_next = redirect_pc_reg;
    // A new edge on the source being taken re-arms it: set beats clear.
    pending_next     = pending_reg | edge_pulse;

    case (state_reg)
      ST_IDLE: begin
        if (take) begin
          epc_w_en_next    = 1'b1;
          epc_w_data_next  = resume_pc;
          redirect_next    = 1'b1;
          redirect_pc_next = win_vec;
          in_service_next  = win_onehot;
          pending_next     = (pending_reg & ~win_onehot) | edge_pulse;
          state_next       = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          in_service_next = '0;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pending_reg     <= '0;
      in_service_reg  <= '0;
      epc_w_en_reg    <= 1'b0;
      epc_w_data_reg  <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      in_service_reg  <= in_service_next;
      epc_w_en_reg    <= epc_w_en_next;
      epc_w_data_reg  <= epc_w_data_next;
      redirect_reg    <= redirect_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  assign epc_w_en    = epc_w_en_reg;
  assign epc_w_data  = epc_w_data_reg;
  assign redirect    = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign in_service  = in_service_reg;
  assign pending     = pending_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: self-checking bench for intr_ctrl. Expected takes are
// queued when stimulus is driven and compared when the strobes appear.
module tb_intr_ctrl;

  localparam int PC_W  = 12;
  localparam int N_SRC = 4;

  logic             clk;
  logic             rst_n;
  logic [N_SRC-1:0] intr_req;
  logic             intr_en;
  logic [N_SRC-1:0] intr_mask;
  logic             safe_pt;
  logic [PC_W-1:0]  resume_pc;
  logic             eret;
  logic             epc_w_en;
  logic [PC_W-1:0]  epc_w_data;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [N_SRC-1:0] in_service;
  logic [N_SRC-1:0] pending;

  intr_ctrl #(
    .PC_W       (PC_W),
    .N_SRC      (N_SRC),
    .VEC_BASE   ('h200),
    .VEC_STRIDE ('h40)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .intr_req    (intr_req),
    .intr_en     (intr_en),
    .intr_mask   (intr_mask),
    .safe_pt     (safe_pt),
    .resume_pc   (resume_pc),
    .eret        (eret),
    .epc_w_en    (epc_w_en),
    .epc_w_data  (epc_w_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_service  (in_service),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]  epc;
    logic [PC_W-1:0]  vec;
    logic [N_SRC-1:0] id;
  } take_t;

  typedef struct {
    int               src;
    logic [N_SRC-1:0] mask;
    logic             en;
    logic [PC_W-1:0]  rpc;
    logic             exp_take;
    logic [PC_W-1:0]  exp_vec;
  } vec_t;

  take_t exp_q[$];
  vec_t  tbl[5];
  int    checks;
  int    errors;
  int    take_cnt;
  logic  prev_strobe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observe strobes #1 after each rising edge.
  task automatic monitor();
    take_t e;
    if (epc_w_en || redirect) begin
      checks++;
      take_cnt++;
      if (prev_strobe) begin
        errors++;
        $display("FAIL back_to_back: strobe in consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_take: epc_w_en=%0b redirect=%0b vec=%0h epc=%0h id=%b",
                 epc_w_en, redirect, redirect_pc, epc_w_data, in_service);
      end else begin
        e = exp_q.pop_front();
        if (!(epc_w_en && redirect && redirect_pc == e.vec &&
              epc_w_data == e.epc && in_service == e.id)) begin
          errors++;
          $display("FAIL take: got en=%0b rd=%0b vec=%0h epc=%0h id=%b expected en=1 rd=1 vec=%0h epc=%0h id=%b",
                   epc_w_en, redirect, redirect_pc, epc_w_data, in_service, e.vec, e.epc, e.id);
        end else begin
          $display("take: id=%b vec=%0h epc=%0h", in_service, redirect_pc, epc_w_data);
        end
      end
    end
    prev_strobe = epc_w_en || redirect;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_take(input logic [PC_W-1:0] epc, input logic [PC_W-1:0] vec,
                             input logic [N_SRC-1:0] id);
    take_t e;
    e.epc = epc;
    e.vec = vec;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic wait_takes(input int target, input int budget);
    for (int i = 0; i < budget && take_cnt < target; i++) tick();
    chk("wait_take", 64'(take_cnt), 64'(target));
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    intr_req = '0;
    eret     = 1'b0;
    ticks(2);
    chk("reset_outs", {epc_w_en, redirect, in_service, pending}, 64'h0);
    chk("reset_data", {epc_w_data, redirect_pc}, 64'h0);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: %0d queued takes never seen", exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b1;
    tick();
  endtask

  int base;

  initial begin
    checks      = 0;
    errors      = 0;
    take_cnt    = 0;
    prev_strobe = 1'b0;
    rst_n       = 1'b0;
    intr_req    = '0;
    intr_en     = 1'b1;
    intr_mask   = 4'b1111;
    safe_pt     = 1'b1;
    resume_pc   = 'h034;
    eret        = 1'b0;

    tbl[0] = '{src: 2, mask: 4'b1111, en: 1'b1, rpc: 'h034, exp_take: 1'b1, exp_vec: 'h280};
    tbl[1] = '{src: 0, mask: 4'b1111, en: 1'b1, rpc: 'h100, exp_take: 1'b1, exp_vec: 'h200};
    tbl[2] = '{src: 3, mask: 4'b1111, en: 1'b1, rpc: 'h3FC, exp_take: 1'b1, exp_vec: 'h2C0};
    tbl[3] = '{src: 1, mask: 4'b1101, en: 1'b1, rpc: 'h010, exp_take: 1'b0, exp_vec: 'h000};
    tbl[4] = '{src: 0, mask: 4'b1111, en: 1'b0, rpc: 'h020, exp_take: 1'b0, exp_vec: 'h000};

    #1;
    chk("async_reset", {epc_w_en, redirect, in_service, pending}, 64'h0);

    // Single-source vectors.
    for (int t = 0; t < 5; t++) begin
      logic [N_SRC-1:0] oh;
      oh = 4'(1 << tbl[t].src);
      reset_dut();
      intr_mask = tbl[t].mask;
      intr_en   = tbl[t].en;
      resume_pc = tbl[t].rpc;
      safe_pt   = 1'b1;
      base      = take_cnt;
      if (tbl[t].exp_take) expect_take(tbl[t].rpc, tbl[t].exp_vec, oh);
      intr_req[tbl[t].src] = 1'b1;
      ticks(3);
      chk($sformatf("v%0d_pending_3cyc", t), 64'(pending), 64'(oh));
      ticks(3);
      chk($sformatf("v%0d_takes", t), 64'(take_cnt - base), tbl[t].exp_take ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_in_service", t), 64'(in_service), tbl[t].exp_take ? 64'(oh) : 64'h0);
      chk($sformatf("v%0d_pending_after", t), 64'(pending), tbl[t].exp_take ? 64'h0 : 64'(oh));
      if (tbl[t].exp_take) begin
        pulse_eret();
        chk($sformatf("v%0d_eret", t), 64'(in_service), 64'h0);
      end
      intr_req = '0;
      ticks(3);
    end
    intr_en = 1'b1;

    // Priority: sources 3 and 1 together.
    reset_dut();
    intr_mask = 4'b1111;
    resume_pc = 'h050;
    base      = take_cnt;
    expect_take('h050, 'h240, 4'b0010);
    intr_req  = 4'b1010;
    ticks(4);
    chk("prio_first", 64'(take_cnt - base), 64'd1);
    chk("prio_pending", 64'(pending), 64'b1000);
    expect_take('h050, 'h2C0, 4'b1000);
    pulse_eret();
    wait_takes(base + 2, 4);
    pulse_eret();
    intr_req = '0;
    ticks(3);

    // Gating by mask, then unmask.
    reset_dut();
    intr_mask = 4'b1110;
    resume_pc = 'h060;
    base      = take_cnt;
    intr_req[0] = 1'b1;
    ticks(6);
    chk("gate_pending", 64'(pending), 64'b0001);
    chk("gate_no_take", 64'(take_cnt - base), 64'd0);
    expect_take('h060, 'h200, 4'b0001);
    intr_mask = 4'b1111;
    wait_takes(base + 1, 3);
    pulse_eret();
    intr_req = '0;
    ticks(3);

    // safe_pt hold for 5 cycles.
    reset_dut();
    safe_pt   = 1'b0;
    resume_pc = 'h070;
    base      = take_cnt;
    intr_req[0] = 1'b1;
    ticks(3);
    ticks(5);
    chk("hold_no_take", 64'(take_cnt - base), 64'd0);
    chk("hold_pending", 64'(pending), 64'b0001);
    expect_take('h070, 'h200, 4'b0001);
    safe_pt = 1'b1;
    tick();
    chk("hold_take_next", 64'(take_cnt - base), 64'd1);

    // Service lockout: new edge on source 0 while it is being serviced.
    intr_req[0] = 1'b0;
    ticks(3);
    intr_req[0] = 1'b1;
    ticks(4);
    chk("lock_pending", 64'(pending), 64'b0001);
    chk("lock_in_service", 64'(in_service), 64'b0001);
    chk("lock_no_take", 64'(take_cnt - base), 64'd1);
    expect_take('h070, 'h200, 4'b0001);
    pulse_eret();
    wait_takes(base + 2, 4);
    pulse_eret();
    intr_req = '0;
    ticks(3);

    // eret in IDLE is ignored; then reset mid-service.
    reset_dut();
    resume_pc = 'h080;
    base      = take_cnt;
    pulse_eret();
    expect_take('h080, 'h200, 4'b0001);
    intr_req[0] = 1'b1;
    wait_takes(base + 1, 6);
    intr_req[2:1] = 2'b11;
    ticks(4);
    chk("rst_pre_pending", 64'(pending), 64'b0110);
    chk("rst_pre_service", 64'(in_service), 64'b0001);
    #2;
    rst_n    = 1'b0;
    intr_req = '0;
    #1;
    chk("rst_async_outs", {epc_w_en, redirect, in_service, pending}, 64'h0);
    chk("rst_async_data", {epc_w_data, redirect_pc}, 64'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(8);
    chk("rst_post_pending", 64'(pending), 64'h0);
    chk("rst_post_service", 64'(in_service), 64'h0);
    chk("rst_post_no_take", 64'(take_cnt - base), 64'd1);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
